psubtractor: RTL and testbench



---
 rtl/psub_pkg.sv | 27 ++
 rtl/rcs_slice.sv | 25 ++
 rtl/psubtractor.sv | 130 +++++++++++++
 tb/tb_psubtractor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/psub_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : psub_pkg
// Brief  : Shared defaults and pipeline stage record for psubtractor.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package psub_pkg;

  localparam int PSUB_WIDTH = 32;
  localparam int PSUB_SLICE = 8;

  // One pipeline stage. diff holds the slices resolved so far (upper bits
  // still zero); a/b keep the full operands so the last stage can form V.
  // chain is the borrow in subtract mode and the carry in add mode, so that
  // it can be presented directly as BO. sub is tied to 1 when the add mode
  // is not built.
  typedef struct packed {
    logic                  valid;
    logic                  chain;
    logic                  sub;
    logic [PSUB_WIDTH-1:0] diff;
    logic [PSUB_WIDTH-1:0] a;
    logic [PSUB_WIDTH-1:0] b;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/rcs_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rcs_slice
// Brief  : SLICE-bit combinational ripple-borrow subtractor, d = a - b - bin.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module rcs_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] w_sum;

  // a + ~b + ~bin equals a - b - bin + 2^SLICE; a missing carry means a borrow.
  assign w_sum = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~bin};
  assign d     = w_sum[SLICE-1:0];
  assign bout  = ~w_sum[SLICE];

endmodule
`default_nettype wire

// File: rtl/psubtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : psubtractor
// Brief  : Pipelined WIDTH-bit subtractor D = A - B - BI, one SLICE-bit
//          ripple-borrow slice per stage, with valid/ready handshake.
//          Optional macro PSUBTRACTOR_ADD_MODE_EN adds a Sub port; Sub=0
//          selects D = A + B + BI with BO as carry-out.
//          WIDTH must equal psub_pkg::PSUB_WIDTH and be a multiple of SLICE.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module psubtractor
  import psub_pkg::*;
#(
  parameter int WIDTH = PSUB_WIDTH,
  parameter int SLICE = PSUB_SLICE
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             V,
  output logic             Out_Valid,
`ifdef PSUBTRACTOR_ADD_MODE_EN
  input  logic             Sub,
`endif
  input  logic             Out_Ready
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;

  logic   w_adv;
  logic   w_sub_in;
  stage_t w_in_stage;
  stage_t w_pipe [STAGES];
  stage_t w_last;

`ifdef PSUBTRACTOR_ADD_MODE_EN
  assign w_sub_in = Sub;
`else
  assign w_sub_in = 1'b1;
`endif

  // The whole pipeline moves as one unless a result is waiting unconsumed.
  assign w_adv    = ~w_last.valid | Out_Ready;
  assign In_Ready = w_adv & Reset_n;

  // Pack the incoming operand as the stage-0 source; no slices resolved yet.
  always_comb begin
    w_in_stage       = '0;
    w_in_stage.valid = In_Valid;
    w_in_stage.chain = BI;
    w_in_stage.sub   = w_sub_in;
    w_in_stage.a     = A;
    w_in_stage.b     = B;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src_w;
    stage_t           stage_d;
    stage_t           stage_q;
    logic [SLICE-1:0] b_eff_w;
    logic [SLICE-1:0] d_slice_w;
    logic             bin_w;
    logic             bout_w;

    if (k == 0) begin : g_head
      assign src_w = w_in_stage;
    end else begin : g_body
      assign src_w = w_pipe[k-1];
    end

    // Add mode reuses the borrow slice: a - ~b - ~carry == a + b + carry.
    assign b_eff_w = src_w.sub ? src_w.b[k*SLICE +: SLICE] : ~src_w.b[k*SLICE +: SLICE];
    assign bin_w   = src_w.sub ? src_w.chain : ~src_w.chain;

    rcs_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a    (src_w.a[k*SLICE +: SLICE]),
      .b    (b_eff_w),
      .bin  (bin_w),
      .d    (d_slice_w),
      .bout (bout_w)
    );

    // Next stage contents: hold on stall, otherwise take the source plus this slice.
    always_comb begin
      stage_d = stage_q;
      if (w_adv) begin
        stage_d                         = src_w;
        stage_d.diff[k*SLICE +: SLICE]  = d_slice_w;
        stage_d.chain                   = src_w.sub ? bout_w : ~bout_w;
      end
    end

    // Stage register; reset discards anything in flight.
    always_ff @(posedge Clock) begin
      if (!Reset_n) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign w_pipe[k] = stage_q;
  end

  assign w_last    = w_pipe[LAST];
  assign D         = w_last.diff;
  assign BO        = w_last.chain;
  assign Out_Valid = w_last.valid;

  // Signed overflow: operand sign relation depends on add vs subtract.
  always_comb begin
    V = 1'b0;
    if (w_last.sub) begin
      V = (w_last.a[WIDTH-1] ^ w_last.b[WIDTH-1]) & (w_last.diff[WIDTH-1] ^ w_last.a[WIDTH-1]);
    end else begin
      V = ~(w_last.a[WIDTH-1] ^ w_last.b[WIDTH-1]) & (w_last.diff[WIDTH-1] ^ w_last.a[WIDTH-1]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psubtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_psubtractor
// Brief  : Self-checking bench for psubtractor: directed cases plus random
//          stream with backpressure, against an arithmetic reference model.
//          Honours PSUBTRACTOR_ADD_MODE_EN.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_psubtractor;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] d;
  logic        bo;
  logic        v;
  logic        out_valid;
  logic        out_ready;
  logic        sub;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q [$];
  logic        stall_prev = 1'b0;
  logic [33:0] res_prev   = '0;

  psubtractor dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .A         (a),
    .B         (b),
    .BI        (bi),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .D         (d),
    .BO        (bo),
    .V         (v),
    .Out_Valid (out_valid),
`ifdef PSUBTRACTOR_ADD_MODE_EN
    .Sub       (sub),
`endif
    .Out_Ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic, result packed as {V, BO, D}.
  function automatic logic [33:0] ref_calc(input logic [31:0] x, input logic [31:0] y,
                                           input logic c, input logic s);
    logic [32:0] r;
    logic        ov;
    if (s) begin
      r  = {1'b0, x} - {1'b0, y} - {32'd0, c};
      ov = (x[31] != y[31]) && (r[31] != x[31]);
    end else begin
      r  = {1'b0, x} + {1'b0, y} + {32'd0, c};
      ov = (x[31] == y[31]) && (r[31] != x[31]);
    end
    return {ov, r};
  endfunction

  // One clock cycle: observe handshakes 1ns after the falling edge, then
  // let the rising edge happen and return at the next falling edge.
  task automatic tick();
    logic [33:0] e;
    #1;
    if (!rst_n) begin
      check("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    end else begin
      check("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (stall_prev) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_hold", {30'd0, v, bo, d}, {30'd0, res_prev});
      end
      if (out_valid && exp_q.size() == 0) begin
        check("spurious_valid", {63'd0, out_valid}, 64'd0);
      end else if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("result", {30'd0, v, bo, d}, {30'd0, e});
      end
      if (in_valid && in_ready) exp_q.push_back(ref_calc(a, b, bi, sub));
      stall_prev = out_valid && !out_ready;
      res_prev   = {v, bo, d};
    end
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c);
    a = x; b = y; bi = c; in_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; a = '0; b = '0; bi = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; sub = 1'b1;
    @(negedge clk);
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_d", {32'd0, d}, 64'd0);
    check("rst_bo_v", {62'd0, bo, v}, 64'd0);
    rst_n = 1'b1;

    // Basic: latency of 4 edges, one-cycle Out_Valid pulse.
    send(32'd5, 32'd3, 1'b0);
    idle();
    idle();
    check("basic_not_yet", {63'd0, out_valid}, 64'd0);
    idle();
    check("basic_valid", {63'd0, out_valid}, 64'd1);
    check("basic_d", {30'd0, v, bo, d}, {30'd0, 2'b00, 32'h0000_0002});
    idle();
    check("basic_pulse", {63'd0, out_valid}, 64'd0);

    // Wrap-around and signed overflow.
    send(32'h0000_0000, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0);
    idle();
    idle();
    check("wrap_neg", {30'd0, v, bo, d}, {30'd0, 2'b01, 32'hFFFF_FFFF});
    idle();
    check("wrap_ovf", {30'd0, v, bo, d}, {30'd0, 2'b10, 32'h7FFF_FFFF});
    idle();

    // Cross-slice borrow with back-to-back operands.
    send(32'h0100_0000, 32'h0000_0001, 1'b0);
    send(32'd10, 32'd3, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'd0, 32'd0, 1'b0);
    check("stream0", {31'd0, out_valid, bo, d}, {31'd0, 2'b10, 32'h00FF_FFFF});
    idle();
    check("stream1", {31'd0, out_valid, bo, d}, {31'd0, 2'b10, 32'h0000_0007});
    idle();
    check("stream2", {31'd0, out_valid, bo, d}, {31'd0, 2'b11, 32'hFFFF_FFFF});
    idle();
    check("stream3", {31'd0, out_valid, bo, d}, {31'd0, 2'b10, 32'h0000_0000});
    idle();
    idle();

    // Backpressure: full pipeline, consumer stalls 3 cycles.
    for (int i = 0; i < 4; i++) send(32'd100 + i, 32'd7 * i, i[0]);
    out_ready = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1; bi = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_d", {32'd0, d}, 64'd100);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    check("bp_drained", exp_q.size(), 64'd0);

    // Reset with three operations in flight.
    send(32'd1, 32'd1, 1'b0);
    send(32'd2, 32'd1, 1'b0);
    send(32'd3, 32'd1, 1'b0);
    rst_n = 1'b0;
    idle();
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_d", {32'd0, d}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      check("no_stale", {63'd0, out_valid}, 64'd0);
    end

`ifdef PSUBTRACTOR_ADD_MODE_EN
    sub = 1'b0;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    idle();
    idle();
    check("add_carry", {30'd0, v, bo, d}, {30'd0, 2'b01, 32'h0000_0000});
    idle();
    check("add_ovf", {30'd0, v, bo, d}, {30'd0, 2'b10, 32'h8000_0000});
    idle();
    sub = 1'b1;
`endif

    // Random stream with random bubbles and backpressure.
    for (int i = 0; i < 400; i++) begin
      a         = rand_word();
      b         = rand_word();
      bi        = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef PSUBTRACTOR_ADD_MODE_EN
      sub       = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) idle();
    check("final_drained", exp_q.size(), 64'd0);
    check("final_idle", {63'd0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
